// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - state encoding, BCD field layout and preset validation for watch_ctrl
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LOAD  = 2'b11
  } state_t;

  localparam int PRESET_BITS = 28;
  localparam int DISP_BITS   = 24;
  localparam int DIGIT_W     = 4;
  localparam int DIGIT_MAX   = 9;
  localparam int TENS_MAX    = 5;

  // Preset layout {min1,min0,sec1,sec0,ms2,ms1,ms0}
  localparam int PRE_MIN1_LSB = 24;
  localparam int PRE_MIN0_LSB = 20;
  localparam int PRE_SEC1_LSB = 16;
  localparam int PRE_SEC0_LSB = 12;
  localparam int PRE_MS2_LSB  = 8;
  localparam int PRE_MS1_LSB  = 4;
  localparam int PRE_MS0_LSB  = 0;

  // Display layout {min1,min0,sec1,sec0,ms2,ms1}
  localparam int DISP_MIN1_LSB = 20;
  localparam int DISP_MIN0_LSB = 16;
  localparam int DISP_SEC1_LSB = 12;
  localparam int DISP_SEC0_LSB = 8;
  localparam int DISP_MS2_LSB  = 4;
  localparam int DISP_MS1_LSB  = 0;

  // A preset is loadable only if every digit is BCD and the tens of minutes/seconds are 0..5
  function automatic logic preset_ok(input logic [PRESET_BITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < PRESET_BITS / DIGIT_W; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > 4'(DIGIT_MAX)) ok = 1'b0;
    end
    if (v[PRE_MIN1_LSB +: DIGIT_W] > 4'(TENS_MAX)) ok = 1'b0;
    if (v[PRE_SEC1_LSB +: DIGIT_W] > 4'(TENS_MAX)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchronizer, stable-level counter and press pulse
module key_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_evt
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          w_differs;

  // Until armed, the counter qualifies a release: a key held across reset must be let go first
  assign w_differs = r_armed ? (r_sync1 != r_level) : !r_sync1;

  // Press event fires in the last cycle of a qualified high run, one cycle before the level flips
  assign o_evt = r_armed && r_sync1 && !r_level && (r_cnt == CNT_LAST);

  // Two-flop synchronizer for the asynchronous key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_key;
      r_sync1 <= r_sync0;
    end
  end

  // Accept a level change only after DEBOUNCE_MS consecutive differing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_differs) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      if (r_armed) r_level <= r_sync1;
      else         r_armed <= 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// rtl/watch_ctrl.sv - stopwatch control FSM with key debounce and preset checks; lap freeze under WATCH_LAP_EN
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int PRESET_W    = PRESET_BITS,
  parameter int DISP_W      = DISP_BITS
) (
  input  logic                clk_1Khz,
  input  logic                rst,
  input  logic                key_ss,
  input  logic                key_clr,
  input  logic                key_lap,
  input  logic                set_valid,
  input  logic [PRESET_W-1:0] set_value,
  input  logic [DISP_W-1:0]   cnt_dispbuf,
  output logic                en,
  output logic                load,
  output logic [PRESET_W-1:0] preset,
  output logic [DISP_W-1:0]   disp_out,
  output logic [1:0]          state,
  output logic                set_err,
  output logic                lap_hold
);

  state_t              r_state;
  logic                r_en;
  logic                r_load;
  logic                r_set_err;
  logic [PRESET_W-1:0] r_preset;

  logic w_ss_evt;
  logic w_clr_evt;
  logic w_stopped;
  logic w_take_clr;
  logic w_take_ss;
  logic w_take_set;
  logic w_bad_set;
  logic w_preset_ok;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_ss (
    .clk(clk_1Khz), .rst_n(rst), .i_key(key_ss), .o_evt(w_ss_evt)
  );

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_clr (
    .clk(clk_1Khz), .rst_n(rst), .i_key(key_clr), .o_evt(w_clr_evt)
  );

  // Clear beats start/stop beats preset; losers are simply dropped
  assign w_preset_ok = preset_ok(set_value);
  assign w_stopped   = (r_state == ST_IDLE) || (r_state == ST_PAUSE);
  assign w_take_clr  = w_stopped && w_clr_evt;
  assign w_take_ss   = w_stopped && !w_clr_evt && w_ss_evt;
  assign w_take_set  = w_stopped && !w_clr_evt && !w_ss_evt && set_valid && w_preset_ok;
  assign w_bad_set   = w_stopped && !w_clr_evt && !w_ss_evt && set_valid && !w_preset_ok;

  assign en      = r_en;
  assign load    = r_load;
  assign preset  = r_preset;
  assign state   = r_state;
  assign set_err = r_set_err;

  // Main control FSM with registered en/load/preset/set_err
  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_en      <= 1'b0;
      r_load    <= 1'b0;
      r_set_err <= 1'b0;
      r_preset  <= '0;
    end else begin
      r_load    <= 1'b0;
      r_set_err <= w_bad_set;
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          if (w_take_clr) begin
            r_preset <= '0;
            r_load   <= 1'b1;
            r_en     <= 1'b0;
            r_state  <= ST_LOAD;
          end else if (w_take_ss) begin
            r_en    <= 1'b1;
            r_state <= ST_RUN;
          end else if (w_take_set) begin
            r_preset <= set_value;
            r_load   <= 1'b1;
            r_en     <= 1'b0;
            r_state  <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (w_ss_evt) begin
            r_en    <= 1'b0;
            r_state <= ST_PAUSE;
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WATCH_LAP_EN
  logic              w_lap_evt;
  logic              r_lap_hold;
  logic [DISP_W-1:0] r_lap;

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_lap (
    .clk(clk_1Khz), .rst_n(rst), .i_key(key_lap), .o_evt(w_lap_evt)
  );

  assign lap_hold = r_lap_hold;
  assign disp_out = r_lap_hold ? r_lap : cnt_dispbuf;

  // Lap freeze: toggled in RUN, released in PAUSE, dropped by clear or any load
  always_ff @(posedge clk_1Khz or negedge rst) begin
    if (!rst) begin
      r_lap_hold <= 1'b0;
      r_lap      <= '0;
    end else if (w_clr_evt || w_take_set) begin
      r_lap_hold <= 1'b0;
    end else if ((r_state == ST_RUN) && w_lap_evt) begin
      r_lap_hold <= !r_lap_hold;
      if (!r_lap_hold) r_lap <= cnt_dispbuf;
    end else if ((r_state == ST_PAUSE) && w_lap_evt && r_lap_hold) begin
      r_lap_hold <= 1'b0;
    end
  end
`else
  logic w_unused_key_lap;

  assign w_unused_key_lap = key_lap;
  assign lap_hold         = 1'b0;
  assign disp_out         = cnt_dispbuf;
`endif

endmodule

// File: doc/watch_ctrl.md
Name: watch_ctrl

Overview:
- Control FSM for the stopwatch counter chain. It turns raw push-button inputs and a preset request into the counter's EN, load and preset controls.
- Debounces the three keys, validates BCD presets and optionally freezes the displayed time for lap/split readout.
- Sits between the key/keyboard front end and the counter. Its display output feeds the display module.

Parameters:
- DEBOUNCE_MS, 20, consecutive stable cycles (1 ms each) needed to accept a key level change.
- PRESET_W, 28, preset width: seven BCD digits.
- DISP_W, 24, display buffer width: six BCD digits.

Ports:
- clk_1Khz  in  1  1 kHz system clock.
- rst  in  1  asynchronous, active-low reset.
- key_ss  in  1  raw start/stop key, active-high, asynchronous to clk.
- key_clr  in  1  raw clear key, active-high.
- key_lap  in  1  raw lap key, active-high.
- set_valid  in  1  one-cycle request to load set_value.
- set_value  in  28  preset digits {min1,min0,sec1,sec0,ms2,ms1,ms0}, 4 bits each, MSB first.
- cnt_dispbuf  in  24  live counter display {min1,min0,sec1,sec0,ms2,ms1}.
- en  out  1  counter enable.
- load  out  1  counter synchronous preset strobe.
- preset  out  28  value presented to the counter.
- disp_out  out  24  value to the display module.
- state  out  2  current FSM state.
- set_err  out  1  one-cycle pulse when a preset is rejected.
- lap_hold  out  1  display is frozen.

Behaviour:
Reset (rst=0): all outputs and internal registers clear immediately.
- state=IDLE, en=0, load=0, preset=0, set_err=0, lap_hold=0.
- Debouncers are cleared to the released state.

Debounce (one instance per key):
- 2-FF synchronizer, then a stable-level counter.
- A press is accepted after DEBOUNCE_MS consecutive synchronized-high cycles. It produces a single-cycle event pulse.
- The key re-arms only after DEBOUNCE_MS consecutive low cycles. Holding a key produces exactly one event.
- Any glitch shorter than DEBOUNCE_MS restarts the count.
- Latency from clean press to event: DEBOUNCE_MS+2 cycles.

States (encoding in package): IDLE=00, RUN=01, PAUSE=10, LOAD=11.
- IDLE: ss_evt -> RUN. clr_evt -> LOAD with preset=0. Valid set_valid -> latch set_value into preset, go to LOAD.
- RUN: en=1. ss_evt -> PAUSE. clr_evt and set_valid are ignored.
- PAUSE: ss_evt -> RUN. clr_evt -> LOAD with preset=0. Valid set_valid -> latch preset, go to LOAD.
- LOAD: load=1 and en=0 for exactly one cycle, then unconditionally IDLE. Events arriving in LOAD are dropped.
- Simultaneous events in one cycle: priority is clr_evt, then ss_evt, then set_valid. Lower-priority events are dropped, not queued.

Preset validation:
- Reject if any digit is >9, or min1 >5, or sec1 >5.
- On rejection: set_err=1 for one cycle, state unchanged, preset unchanged.
- set_valid in RUN or LOAD is ignored without an error.
- preset holds its value between loads. Clear forces preset=0 in the same edge as entry to LOAD.

Output timing:
- en, load and state are registered: they change on the edge after the triggering event.
- en falls on the same edge that enters PAUSE.

Optional Feature:
- Macro: WATCH_LAP_EN.
- Defined:
  - lap_evt in RUN toggles lap_hold. On the rising toggle, cnt_dispbuf is captured into the lap register.
  - disp_out = lap register while lap_hold=1, else cnt_dispbuf.
  - lap_evt in PAUSE with lap_hold=1 clears lap_hold.
  - clr_evt or entry to LOAD clears lap_hold.
  - The counter is never stopped by lap.
- Undefined:
  - key_lap is unused and its debouncer is not instantiated.
  - lap_hold is tied to 0.
  - disp_out = cnt_dispbuf combinationally.

Decomposition:
- Package watch_pkg holds:
  - state encoding constants;
  - digit field offsets for the preset and display layouts;
  - DIGIT_MAX=9 and TENS_MAX=5.
- One sub-module, key_debounce (synchronizer, counter, edge pulse), instantiated once per key.
- The FSM and validation stay in watch_ctrl.

Test Plan:
1. Reset: assert rst=0 mid-RUN -> en, load and state go to 0 immediately. key_ss held through reset release gives no event until it is released and pressed again.
2. Debounce: key_ss pulses of 5 ms repeated, then a 25 ms press -> no transition for the short pulses. Exactly one IDLE->RUN transition, en=1 at cycle 22 after the clean press. A 2 s hold gives no further event.
3. Run/pause/clear: ss, ss, clr -> state sequence 01, 10, 11 (load=1 for 1 cycle with preset=0), then 00. A clr pressed during RUN -> ignored.
4. Preset: set_value=28'h5959999 in IDLE -> LOAD one cycle, preset=5959999. set_value=28'h6000000 -> set_err pulse, preset unchanged. set_valid together with clr_evt -> clear wins, preset=0.
5. Lap (WATCH_LAP_EN): in RUN with cnt_dispbuf=24'h012345, lap press -> disp_out holds 012345 while cnt_dispbuf advances and en stays 1. A second lap press -> disp_out tracks live again.
6. Lap compiled out: lap press -> lap_hold=0, disp_out == cnt_dispbuf every cycle.
